pc_flow_ctrl: RTL and testbench
===============================

Name: pc_flow_ctrl

Overview:
- Sequencer for the 32-bit PC register. Each cycle it decides whether the PC advances (pc_enable) and which value it loads (new_pc): sequential PC+4, branch target, jump target or jump-register target.
- It honours instruction-memory readiness and pipeline stall requests. It holds one redirect pending while the fetch is blocked.
- It raises the IF/ID flush on the cycle a redirect is applied.
- Sits between the hazard unit / EX-stage branch logic and the PC register. Its outputs drive the PC register's enable and NewPC inputs directly.

Parameters:
- N, 32, PC width in bits.
- RESET_PC, 32'h0040_0000, PC value driven on new_pc during reset and boot.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (sampled on posedge clk).
- pc_value  input  N  current PC register output.
- imem_ready  input  1  instruction memory can accept a fetch this cycle.
- stall  input  1  hazard-unit stall request (load-use etc.).
- branch_taken  input  1  EX-stage branch resolved taken.
- branch_target  input  N  branch destination.
- jump  input  1  J/JAL redirect.
- jump_target  input  N  jump destination.
- jr  input  1  JR redirect.
- jr_target  input  N  register destination.
- fetch_req  output  1  fetch request to instruction memory.
- pc_enable  output  1  load enable for the PC register.
- new_pc  output  N  next PC value.
- if_id_flush  output  1  squash the instruction in IF/ID.
- misalign_err  output  1  sticky flag: a redirect target had bits[1:0] != 0.
- stall_cycles  output  CNT_W  saturating count of blocked cycles.

Behaviour:
- State machine states: BOOT, RUN, PEND. Registers: state, pend_target (N bits), misalign_err, stall_cycles.
- Reset (reset==0 at posedge clk):
  - state <= BOOT, pend_target <= 0, misalign_err <= 0, stall_cycles <= 0.
  - While reset is low, outputs are forced to: fetch_req=0, pc_enable=0, if_id_flush=0, new_pc=RESET_PC.
  - Reset asserted mid-operation discards any pending redirect.
- Redirect select: redirect = jr | jump | branch_taken.
  - Priority: jr > jump > branch_taken.
  - sel_target is the target of the winning source, with bits[1:0] forced to 0.
  - If the raw winning target has bits[1:0] != 0, misalign_err <= 1. It stays set until reset.
- Outputs are combinational from state, inputs and pend_target; zero latency from input to output.
- go = imem_ready & ~stall.
- BOOT:
  - fetch_req=0, pc_enable=0, new_pc=RESET_PC.
  - Next state is RUN unconditionally; lasts exactly one cycle.
  - Redirect inputs are ignored.
- RUN:
  - fetch_req=1.
  - If go: pc_enable=1, new_pc = redirect ? sel_target : pc_value+4, if_id_flush=redirect. Stay in RUN.
  - If not go: pc_enable=0, if_id_flush=0. If redirect, pend_target <= sel_target and go to PEND; otherwise stay in RUN.
- PEND:
  - fetch_req=1.
  - Redirect inputs are ignored and misalign_err is not updated: the older redirect owns the path.
  - If go: pc_enable=1, new_pc=pend_target, if_id_flush=1, next state RUN.
  - If not go: pc_enable=0, hold.
- Arithmetic:
  - pc_value+4 is computed modulo 2^N. For example, 32'hFFFF_FFFC wraps to 32'h0000_0000.
- new_pc when pc_enable=0:
  - RUN: shows pc_value+4.
  - PEND: shows pend_target.
  - The value is don't-care for the PC register but must be stable.
- stall_cycles:
  - Increments on every posedge in RUN or PEND with pc_enable=0.
  - Saturates at 2^CNT_W-1; no wrap.
- Simultaneous events:
  - stall and ~imem_ready together: treated as a single blocked cycle, counted once.
  - redirect and go in the same RUN cycle: redirect applied immediately; PEND is not entered.

Test Plan:
- Reset low 2 cycles, then release with imem_ready=1 and no stall -> one BOOT cycle with pc_enable=0; then pc_enable=1 every cycle, new_pc = 0x0040_0004, 0x0040_0008, ... as pc_value follows.
- pc_value=0x0040_0010, jr=1 with jr_target=0x0040_0100, jump=1 with jump_target=0x0040_0200, branch_taken=1, go=1 -> new_pc=0x0040_0100, pc_enable=1, if_id_flush=1 in the same cycle.
- branch_taken=1 with target 0x0040_0080 while imem_ready=0 for 3 cycles; jump=1 with target 0x0040_0300 on the 2nd cycle -> state PEND, pc_enable=0 for 3 cycles, stall_cycles=3; on ready: new_pc=0x0040_0080, flush=1, jump ignored.
- jump_target=0x0040_0102 with go=1 -> new_pc=0x0040_0100, misalign_err=1 and still 1 after 10 further cycles.
- pc_value=32'hFFFF_FFFC with go=1 -> new_pc=0x0000_0000; separately, stall held 70000 cycles -> stall_cycles saturates at 0xFFFF.
- Enter PEND with pend_target=0x0040_0400, assert reset for one cycle -> outputs show the forced reset values; after release: BOOT then RUN, 0x0040_0400 never appears on new_pc.

Source files
------------

// File: rtl/pc_flow_ctrl_if.sv
// PC sequencer bus: pipeline-side requests and redirect sources in, PC register controls out.
interface pc_flow_ctrl_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic [N-1:0]     pc_value;
  logic             imem_ready;
  logic             stall;
  logic             branch_taken;
  logic [N-1:0]     branch_target;
  logic             jump;
  logic [N-1:0]     jump_target;
  logic             jr;
  logic [N-1:0]     jr_target;
  logic             fetch_req;
  logic             pc_enable;
  logic [N-1:0]     new_pc;
  logic             if_id_flush;
  logic             misalign_err;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline / hazard side: drives requests, observes PC controls.
  modport master (
    output pc_value, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, jr, jr_target,
    input  fetch_req, pc_enable, new_pc, if_id_flush, misalign_err, stall_cycles
  );

  // Sequencer side.
  modport slave (
    input  pc_value, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, jr, jr_target,
    output fetch_req, pc_enable, new_pc, if_id_flush, misalign_err, stall_cycles
  );
endinterface

// File: rtl/pc_flow_ctrl.sv
// PC sequencer: chooses PC+4 or a redirect target, holds one redirect while
// fetch is blocked, flags misaligned targets and counts blocked cycles.
module pc_flow_ctrl #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0040_0000,
  parameter int           CNT_W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  pc_flow_ctrl_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  localparam logic [N-1:0] PC_STEP = N'(4);

  state_t           state_reg, state_next;
  logic [N-1:0]     pend_target_reg, pend_target_next;
  logic             misalign_reg, misalign_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic             go;
  logic             redirect;
  logic [N-1:0]     raw_target;
  logic [N-1:0]     sel_target;
  logic [N-1:0]     pc_plus4;

  logic             fetch_int, enable_int, flush_int;
  logic [N-1:0]     new_pc_int;

  // Redirect arbitration (jr > jump > branch) and the sequential increment.
  always_comb begin
    go         = bus.imem_ready & ~bus.stall;
    redirect   = bus.jr | bus.jump | bus.branch_taken;
    raw_target = bus.jr   ? bus.jr_target   :
                 bus.jump ? bus.jump_target : bus.branch_target;
    sel_target = {raw_target[N-1:2], 2'b00};
    pc_plus4   = bus.pc_value + PC_STEP;
  end

  // Next-state and output decode; reset forces a quiet, boot-vector output.
  always_comb begin
    state_next       = state_reg;
    pend_target_next = pend_target_reg;
    misalign_next    = misalign_reg;
    fetch_int        = 1'b0;
    enable_int       = 1'b0;
    flush_int        = 1'b0;
    new_pc_int       = RESET_PC;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        fetch_int  = 1'b1;
        new_pc_int = pc_plus4;
        if (redirect && (raw_target[1:0] != 2'b00))
          misalign_next = 1'b1;
        if (go) begin
          enable_int = 1'b1;
          if (redirect) begin
            new_pc_int = sel_target;
            flush_int  = 1'b1;
          end
        end else if (redirect) begin
          // Fetch blocked: park the redirect until the front end can take it.
          pend_target_next = sel_target;
          state_next       = PEND;
        end
      end
      PEND: begin
        // The parked redirect owns the path; new redirects are ignored here.
        fetch_int  = 1'b1;
        new_pc_int = pend_target_reg;
        if (go) begin
          enable_int = 1'b1;
          flush_int  = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
    if (!reset) begin
      fetch_int  = 1'b0;
      enable_int = 1'b0;
      flush_int  = 1'b0;
      new_pc_int = RESET_PC;
    end
  end

  // Saturating blocked-cycle counter; stall and not-ready together count once.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if ((state_reg != BOOT) && !go && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= BOOT;
      pend_target_reg <= '0;
      misalign_reg    <= 1'b0;
      stall_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      pend_target_reg <= pend_target_next;
      misalign_reg    <= misalign_next;
      stall_cnt_reg   <= stall_cnt_next;
    end
  end

  assign bus.fetch_req    = fetch_int;
  assign bus.pc_enable    = enable_int;
  assign bus.new_pc       = new_pc_int;
  assign bus.if_id_flush  = flush_int;
  assign bus.misalign_err = misalign_reg;
  assign bus.stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: directed scenarios plus random traffic
// compared against a behavioural model (boot flag, pending-redirect queue, counters).
module tb_pc_flow_ctrl;
  localparam int          N        = 32;
  localparam int          CNT_W    = 16;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          CNT_MAX  = 65535;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_flow_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus_i ();

  pc_flow_ctrl #(.N(N), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_i)
  );

  int checks   = 0;
  int failures = 0;

  // Model state
  bit          m_known = 1'b0;
  bit          m_boot  = 1'b1;
  logic [31:0] m_pend[$];
  bit          m_merr  = 1'b0;
  int          m_scnt  = 0;

  bit          follow = 1'b1;
  bit          quiet  = 1'b0;
  int          cyc    = 0;

  logic [31:0] obs_new;
  logic        obs_en, obs_flush, obs_fetch, obs_merr;
  logic [15:0] obs_sc;
  bit          saw_stale;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus_i.imem_ready    = 1'b1;
    bus_i.stall         = 1'b0;
    bus_i.branch_taken  = 1'b0;
    bus_i.branch_target = 32'h0;
    bus_i.jump          = 1'b0;
    bus_i.jump_target   = 32'h0;
    bus_i.jr            = 1'b0;
    bus_i.jr_target     = 32'h0;
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic run_cycle();
    logic        go, redir;
    logic [31:0] raw, e_new;
    logic        e_fetch, e_en, e_flush;
    #1;
    go    = bus_i.imem_ready && !bus_i.stall;
    redir = bus_i.jr || bus_i.jump || bus_i.branch_taken;
    raw   = bus_i.jr ? bus_i.jr_target : (bus_i.jump ? bus_i.jump_target : bus_i.branch_target);
    if (!reset || m_boot) begin
      e_fetch = 1'b0; e_en = 1'b0; e_flush = 1'b0; e_new = RESET_PC;
    end else if (m_pend.size() != 0) begin
      e_fetch = 1'b1; e_en = go; e_flush = go; e_new = m_pend[0];
    end else begin
      e_fetch = 1'b1; e_en = go; e_flush = go && redir;
      e_new   = (go && redir) ? (raw & ~32'h3) : bus_i.pc_value + 32'd4;
    end
    obs_new   = bus_i.new_pc;
    obs_en    = bus_i.pc_enable;
    obs_flush = bus_i.if_id_flush;
    obs_fetch = bus_i.fetch_req;
    obs_merr  = bus_i.misalign_err;
    obs_sc    = bus_i.stall_cycles;
    check_value("fetch_req",   32'(obs_fetch), 32'(e_fetch));
    check_value("pc_enable",   32'(obs_en),    32'(e_en));
    check_value("if_id_flush", 32'(obs_flush), 32'(e_flush));
    check_value("new_pc",      obs_new,        e_new);
    if (m_known) begin
      check_value("misalign_err", 32'(obs_merr), 32'(m_merr));
      check_value("stall_cycles", 32'(obs_sc),   32'(m_scnt));
    end
    if (!quiet)
      $display("cyc=%0d rst=%b go=%b redir=%b pc=%h new_pc=%h en=%b flush=%b merr=%b sc=%0d",
               cyc, reset, go, redir, bus_i.pc_value, obs_new, obs_en, obs_flush, obs_merr, obs_sc);
    @(posedge clk);
    if (!reset) begin
      m_known = 1'b1; m_boot = 1'b1; m_pend.delete(); m_merr = 1'b0; m_scnt = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (!go && m_scnt < CNT_MAX) m_scnt++;
      if (m_pend.size() != 0) begin
        if (go) void'(m_pend.pop_front());
      end else if (redir) begin
        if (raw[1:0] != 2'b00) m_merr = 1'b1;
        if (!go) m_pend.push_back(raw & ~32'h3);
      end
    end
    @(negedge clk);
    if (follow && e_en) bus_i.pc_value = e_new;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) run_cycle();
    reset = 1'b1;
    run_cycle();  // BOOT cycle
    bus_i.pc_value = RESET_PC;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    reset = 1'b0;
    set_idle();
    bus_i.pc_value = RESET_PC;
    @(negedge clk);

    // Reset two cycles, boot, then sequential fetch
    run_cycle();
    check_value("rst_new_pc", obs_new, RESET_PC);
    check_value("rst_en", 32'(obs_en), 32'd0);
    run_cycle();
    reset = 1'b1;
    run_cycle();
    check_value("boot_en", 32'(obs_en), 32'd0);
    run_cycle();
    check_value("seq1", obs_new, 32'h0040_0004);
    run_cycle();
    check_value("seq2", obs_new, 32'h0040_0008);
    run_cycle();
    check_value("seq3", obs_new, 32'h0040_000C);

    // Priority: jr wins over jump and branch
    bus_i.pc_value = 32'h0040_0010;
    bus_i.jr = 1'b1;           bus_i.jr_target     = 32'h0040_0100;
    bus_i.jump = 1'b1;         bus_i.jump_target   = 32'h0040_0200;
    bus_i.branch_taken = 1'b1; bus_i.branch_target = 32'h0040_0040;
    run_cycle();
    check_value("prio_new_pc", obs_new, 32'h0040_0100);
    check_value("prio_flush", 32'(obs_flush), 32'd1);
    set_idle();

    // Branch while not ready, jump during PEND ignored
    do_reset(1);
    bus_i.imem_ready = 1'b0;
    bus_i.branch_taken = 1'b1; bus_i.branch_target = 32'h0040_0080;
    run_cycle();
    bus_i.jump = 1'b1; bus_i.jump_target = 32'h0040_0300;
    run_cycle();
    bus_i.jump = 1'b0;
    run_cycle();
    check_value("pend_en", 32'(obs_en), 32'd0);
    set_idle();
    run_cycle();
    check_value("pend_new_pc", obs_new, 32'h0040_0080);
    check_value("pend_flush", 32'(obs_flush), 32'd1);
    check_value("pend_stall_cnt", 32'(obs_sc), 32'd3);

    // Misaligned jump target: sticky error
    bus_i.jump = 1'b1; bus_i.jump_target = 32'h0040_0102;
    run_cycle();
    check_value("mis_new_pc", obs_new, 32'h0040_0100);
    set_idle();
    for (int i = 0; i < 11; i++) run_cycle();
    check_value("mis_sticky", 32'(obs_merr), 32'd1);

    // PC+4 wraps
    bus_i.pc_value = 32'hFFFF_FFFC;
    run_cycle();
    check_value("wrap_new_pc", obs_new, 32'h0000_0000);

    // Reset discards a pending redirect
    bus_i.pc_value = RESET_PC;
    bus_i.imem_ready = 1'b0;
    bus_i.branch_taken = 1'b1; bus_i.branch_target = 32'h0040_0400;
    run_cycle();
    set_idle();
    bus_i.imem_ready = 1'b0;
    reset = 1'b0;
    run_cycle();
    check_value("rstp_new_pc", obs_new, RESET_PC);
    check_value("rstp_fetch", 32'(obs_fetch), 32'd0);
    reset = 1'b1;
    bus_i.imem_ready = 1'b1;
    bus_i.pc_value = RESET_PC;
    saw_stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (obs_new == 32'h0040_0400) saw_stale = 1'b1;
    end
    check_value("rstp_no_stale", 32'(saw_stale), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      reset               = ($urandom_range(0, 49) != 0);
      bus_i.imem_ready    = ($urandom_range(0, 3) != 0);
      bus_i.stall         = ($urandom_range(0, 4) == 0);
      bus_i.jr            = ($urandom_range(0, 7) == 0);
      bus_i.jump          = ($urandom_range(0, 6) == 0);
      bus_i.branch_taken  = ($urandom_range(0, 5) == 0);
      bus_i.jr_target     = rand_target();
      bus_i.jump_target   = rand_target();
      bus_i.branch_target = rand_target();
      if ($urandom_range(0, 19) == 0) bus_i.pc_value = rand_target();
      run_cycle();
    end

    // Stall counter saturation
    set_idle();
    do_reset(1);
    bus_i.stall = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 65600; i++) run_cycle();
    quiet = 1'b0;
    run_cycle();
    check_value("sat_stall_cnt", 32'(obs_sc), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
